// File: rtl/gf_power_sbox_iter_if.sv
// Operand/result handshake bundle for the iterative GF(2^N) power S-box.
// The master drives operands and takes results; the slave is the S-box.
interface gf_power_sbox_iter_if #(
    parameter int WIDTH = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             busy;

    modport master (
        output in_valid, in_x, in_exp, out_ready,
        input  in_ready, out_valid, out_y, busy
    );

    modport slave (
        input  in_valid, in_x, in_exp, out_ready,
        output in_ready, out_valid, out_y, busy
    );
endinterface

// File: rtl/gf_power_sbox_iter.sv
// Iterative power-map S-box y = x^e over GF(2^WIDTH), MSB-first square-and-multiply.
// One exponent bit per cycle through a single shared multiplier; timing never depends on data.
module gf_power_sbox_iter #(
    parameter int               WIDTH = 6,
    parameter logic [WIDTH:0]   POLY  = 7'b1000011
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gf_power_sbox_iter_if.slave  sif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] RED = POLY[WIDTH-1:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Multiply by the field generator alpha: shift up and fold the overflow bit back via POLY.
    function automatic logic [WIDTH-1:0] gf_xtime(input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] r;
        r = {a[WIDTH-2:0], 1'b0};
        if (a[WIDTH-1]) begin
            r = r ^ RED;
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) begin
                p = p ^ t;
            end
            t = gf_xtime(t);
        end
        return p;
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_e;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_out_y;
    logic             r_out_valid;
    logic             r_busy;

    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_sq;
    logic [WIDTH-1:0] w_sqx;
    logic [WIDTH-1:0] w_next;

    // Both multiplies are always evaluated so the bit value only steers a mux.
    assign w_sq   = gf_mul(r_acc, r_acc);
    assign w_sqx  = gf_mul(w_sq, r_x);
    assign w_next = r_e[r_cnt] ? w_sqx : w_sq;

    assign w_in_ready = rst_n && ((r_state == S_IDLE) ||
                                  ((r_state == S_DONE) && sif.out_ready));
    assign w_accept   = sif.in_valid && w_in_ready;

    assign sif.in_ready  = w_in_ready;
    assign sif.out_valid = r_out_valid;
    assign sif.out_y     = r_out_y;
    assign sif.busy      = r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_out_y     <= '0;
            r_acc       <= WIDTH'(1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x     <= sif.in_x;
                        r_e     <= sif.in_exp;
                        r_acc   <= WIDTH'(1);
                        r_cnt   <= CNT_W'(WIDTH - 1);
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_out_y     <= w_next;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (sif.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (sif.in_valid) begin
                            r_x     <= sif.in_x;
                            r_e     <= sif.in_exp;
                            r_acc   <= WIDTH'(1);
                            r_cnt   <= CNT_W'(WIDTH - 1);
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf_power_sbox_iter.sv
// Scoreboard bench for gf_power_sbox_iter (WIDTH=6, x^6+x+1): directed vectors, backpressure,
// mid-run reset and all 64x64 operand pairs against a plain polynomial-arithmetic model.
module tb_gf_power_sbox_iter;

    localparam int             W       = 6;
    localparam logic [W:0]     POLY_TB = 7'b1000011;

    typedef struct packed {
        logic [W-1:0] y;
        logic [31:0]  acc_cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   n_issued;
    int   n_results;
    int   rdy_mode;
    exp_t exp_q[$];

    gf_power_sbox_iter_if #(.WIDTH(W)) sif ();

    gf_power_sbox_iter #(.WIDTH(W), .POLY(POLY_TB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // Carry-less product of the two polynomials, then long division by POLY.
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-2:0] p;
        p = '0;
        for (int i = 0; i < W; i++)
            if (b[i]) p = p ^ ((2*W-1)'(a) << i);
        for (int d = 2*W-2; d >= W; d--)
            if (p[d]) p = p ^ ((2*W-1)'(POLY_TB) << (d - W));
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] ref_pow(input logic [W-1:0] x, input logic [W-1:0] e);
        logic [W-1:0] r;
        r = W'(1);
        for (int i = 0; i < int'(e); i++) r = ref_mul(r, x);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1. Holds in_valid until accepted, then scrambles the operand lines.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] e,
                        input logic [W-1:0] y, output int stalls);
        bit done;
        stalls = 0;
        done = 0;
        sif.in_valid = 1'b1;
        sif.in_x     = x;
        sif.in_exp   = e;
        while (!done) begin
            @(negedge clk);
            if (sif.in_ready) begin
                exp_q.push_back('{y: y, acc_cyc: 32'(cyc + 1)});
                n_issued++;
                done = 1;
            end else begin
                stalls++;
                if (stalls > 100) begin
                    check("accept_timeout", 32'(stalls), 32'd0);
                    done = 1;
                end
            end
        end
        tick();
        sif.in_valid = 1'b0;
        sif.in_x     = W'($urandom);
        sif.in_exp   = W'($urandom);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       sif.out_ready = 1'b0;
                1:       sif.out_ready = 1'b1;
                default: sif.out_ready = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Monitor: latency on each rising out_valid, hold stability, and in-order result compare.
    initial begin
        bit           prev_v;
        bit           prev_taken;
        logic [W-1:0] prev_y;
        exp_t         ex;
        prev_v = 0;
        prev_taken = 0;
        prev_y = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_out_valid", 32'(sif.out_valid), 32'd0);
                prev_v = 0;
                prev_taken = 0;
            end else begin
                if (sif.out_valid && !prev_v) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL spurious_result: out_valid with no pending op, out_y=%0h", sif.out_y);
                    end else begin
                        check("latency_edges", 32'(cyc) - exp_q[0].acc_cyc + 32'd1, 32'(W + 1));
                    end
                end
                if (sif.out_valid && prev_v && !prev_taken)
                    check("hold_stable", 32'(sif.out_y), 32'(prev_y));
                if (sif.out_valid && sif.out_ready && exp_q.size() != 0) begin
                    ex = exp_q.pop_front();
                    n_results++;
                    check("result", 32'(sif.out_y), 32'(ex.y));
                end
                prev_v     = sif.out_valid;
                prev_taken = sif.out_valid && sif.out_ready;
                prev_y     = sif.out_y;
            end
        end
    end

    initial begin
        int           st;
        bit           seen;
        logic [W-1:0] vx [7];
        logic [W-1:0] ve [7];
        logic [W-1:0] vy [7];
        vx = '{6'h02, 6'h02, 6'h02, 6'h03, 6'h00, 6'h00, 6'h2B};
        ve = '{6'd20, 6'd62, 6'd63, 6'd1,  6'd20, 6'd0,  6'd0};
        vy = '{6'h3C, 6'h21, 6'h01, 6'h03, 6'h00, 6'h01, 6'h01};

        cyc = 0; n_tests = 0; n_fail = 0; n_issued = 0; n_results = 0;
        rdy_mode = 0;
        rst_n = 1'b0;
        sif.in_valid = 1'b0; sif.in_x = '0; sif.in_exp = '0; sif.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(sif.in_ready), 32'd0);
        check("rst_busy", 32'(sif.busy), 32'd0);
        check("rst_out_y", 32'(sif.out_y), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(sif.in_ready), 32'd1);
        check("idle_busy", 32'(sif.busy), 32'd0);

        // Directed vectors, consumer always ready
        rdy_mode = 1;
        tick();
        for (int i = 0; i < 7; i++) begin
            send(vx[i], ve[i], vy[i], st);
            if (i == 0) begin
                @(negedge clk);
                check("run_busy", 32'(sif.busy), 32'd1);
                check("run_in_ready", 32'(sif.in_ready), 32'd0);
                tick();
            end
        end
        drain(50);
        tick();

        // Backpressure, then take and accept on the same edge
        rdy_mode = 0;
        tick(); tick();
        send(6'h02, 6'd20, 6'h3C, st);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = sif.out_valid;
        end
        check("bp_valid_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(sif.in_ready), 32'd0);
            check("bp_out_y", 32'(sif.out_y), 32'h3C);
            check("bp_out_valid", 32'(sif.out_valid), 32'd1);
        end
        rdy_mode = 1;
        @(posedge clk);
        #1;
        send(6'h02, 6'd62, 6'h21, st);
        check("b2b_stalls", 32'(st), 32'd0);
        drain(50);

        // Reset during RUN cycle 3
        tick();
        send(6'h2B, 6'd45, ref_pow(6'h2B, 6'd45), st);
        tick(); tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(sif.in_ready), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        check("midrst_pending", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            void'(exp_q.pop_back());
            n_issued--;
        end
        @(negedge clk);
        check("post_rst_in_ready", 32'(sif.in_ready), 32'd1);
        check("post_rst_busy", 32'(sif.busy), 32'd0);
        repeat (10) @(negedge clk);
        check("post_rst_no_valid", 32'(sif.out_valid), 32'd0);
        tick();
        send(6'h02, 6'd20, 6'h3C, st);
        drain(50);

        // All operand pairs with random stalls on both sides
        rdy_mode = 2;
        tick();
        for (int x = 0; x < 64; x++) begin
            for (int e = 0; e < 64; e++) begin
                if ($urandom_range(7) == 0) begin
                    sif.in_x = W'($urandom);
                    sif.in_exp = W'($urandom);
                    tick();
                end
                send(W'(x), W'(e), ref_pow(W'(x), W'(e)), st);
            end
        end
        drain(200);
        check("result_count", 32'(n_results), 32'(n_issued));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
